// File: rtl/freeze_ctrl.sv
// rtl/freeze_ctrl.sv - debounced push-button to freeze toggle / long-press chain reset
module freeze_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int LONG_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic frz,
    output logic chain_rst,
    output logic btn_db,
    output logic busy
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_t;

    logic          sync1_q, sync1_d;
    logic          btn_s_q, btn_s_d;
    logic          btn_db_q, btn_db_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          frz_q, frz_d;
    logic          chain_rst_q, chain_rst_d;
    state_t        state_q, state_d;

    // Synchronizer and debouncer: btn_db only follows btn_s after DEB_CYCLES
    // consecutive disagreeing samples; any agreement restarts the count.
    always_comb begin
        sync1_d   = btn_raw;
        btn_s_d   = sync1_q;
        btn_db_d  = btn_db_q;
        deb_cnt_d = '0;
        if (btn_s_q != btn_db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_db_d  = btn_s_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    // Release is checked before the long-press limit so a release landing on
    // the final hold cycle still counts as a short press.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        frz_d       = frz_q;
        chain_rst_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_db_q) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end
            end
            HELD: begin
                if (!btn_db_q) begin
                    frz_d   = ~frz_q;
                    state_d = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    chain_rst_d = 1'b1;
                    frz_d       = 1'b0;
                    state_d     = LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            LONG: begin
                if (!btn_db_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            btn_db_q    <= 1'b0;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            frz_q       <= 1'b0;
            chain_rst_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            sync1_q     <= sync1_d;
            btn_s_q     <= btn_s_d;
            btn_db_q    <= btn_db_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            frz_q       <= frz_d;
            chain_rst_q <= chain_rst_d;
            state_q     <= state_d;
        end
    end

    assign frz       = frz_q;
    assign chain_rst = chain_rst_q;
    assign btn_db    = btn_db_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_freeze_ctrl.sv
// tb/tb_freeze_ctrl.sv - directed self-checking bench for freeze_ctrl
module tb_freeze_ctrl;

    logic clk;
    logic rst;
    logic btn_raw;
    logic frz;
    logic chain_rst;
    logic btn_db;
    logic busy;

    int n_checks;
    int n_errors;
    int crst_count;

    logic db_at   [0:79];
    logic frz_at  [0:79];
    logic crst_at [0:79];
    logic busy_at [0:79];

    freeze_ctrl #(
        .DEB_CYCLES (4),
        .LONG_CYCLES(20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .frz      (frz),
        .chain_rst(chain_rst),
        .btn_db   (btn_db),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (chain_rst === 1'b1) crst_count++;
    endtask

    // Raw high for 'hi' cycles, observed for 'total' edges; index i = i-th edge after press.
    task automatic run_press(input int hi, input int total);
        btn_raw = 1'b1;
        for (int i = 1; i <= total; i++) begin
            step();
            db_at[i]   = btn_db;
            frz_at[i]  = frz;
            crst_at[i] = chain_rst;
            busy_at[i] = busy;
            if (i == hi) btn_raw = 1'b0;
        end
    endtask

    initial begin
        int c0;
        logic any_db, any_frz, any_busy;
        n_checks   = 0;
        n_errors   = 0;
        crst_count = 0;
        rst        = 1'b0;
        btn_raw    = 1'b1;

        // Reset with button held
        step();
        check("rst_frz", frz, 0);
        check("rst_crst", chain_rst, 0);
        check("rst_db", btn_db, 0);
        check("rst_busy", busy, 0);
        step();
        rst = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            db_at[i]   = btn_db;
            busy_at[i] = busy;
        end
        check("held_after_rst_db5", db_at[5], 0);
        check("held_after_rst_db6", db_at[6], 1);
        check("held_after_rst_busy", busy_at[7], 1);
        btn_raw = 1'b0;
        repeat (7) step();
        check("held_after_rst_toggle", frz, 1);
        rst = 1'b0;
        step();
        check("rst2_frz", frz, 0);
        check("rst2_busy", busy, 0);
        rst = 1'b1;
        repeat (3) step();

        // Bounce: 2-cycle pulses never pass the debouncer
        c0 = crst_count;
        any_db = 1'b0;
        any_frz = 1'b0;
        for (int i = 0; i < 24; i++) begin
            btn_raw = (i < 12) ? ((i % 4) < 2) : 1'b0;
            step();
            any_db  |= btn_db;
            any_frz |= frz;
        end
        check("bounce_db", any_db, 0);
        check("bounce_frz", any_frz, 0);
        check("bounce_crst", crst_count - c0, 0);

        // Short press and repeat
        c0 = crst_count;
        run_press(10, 24);
        check("short_db5", db_at[5], 0);
        check("short_db6", db_at[6], 1);
        check("short_db15", db_at[15], 1);
        check("short_db16", db_at[16], 0);
        check("short_frz16", frz_at[16], 0);
        check("short_frz17", frz_at[17], 1);
        check("short_busy17", busy_at[17], 0);
        run_press(10, 24);
        check("repeat_frz16", frz_at[16], 1);
        check("repeat_frz17", frz_at[17], 0);
        check("short_crst", crst_count - c0, 0);

        // Long press while frozen
        run_press(10, 24);
        check("pre_long_frz", frz_at[17], 1);
        c0 = crst_count;
        run_press(40, 60);
        check("long_crst26", crst_at[26], 0);
        check("long_crst27", crst_at[27], 1);
        check("long_crst28", crst_at[28], 0);
        check("long_frz26", frz_at[26], 1);
        check("long_frz27", frz_at[27], 0);
        check("long_busy46", busy_at[46], 1);
        check("long_busy47", busy_at[47], 0);
        check("long_frz_end", frz_at[60], 0);
        check("long_pulses", crst_count - c0, 1);

        // Boundary: btn_db falls on the edge hold_cnt reaches 19
        c0 = crst_count;
        run_press(20, 40);
        check("bnd_db25", db_at[25], 1);
        check("bnd_db26", db_at[26], 0);
        check("bnd_frz26", frz_at[26], 0);
        check("bnd_frz27", frz_at[27], 1);
        check("bnd_crst", crst_count - c0, 0);

        // One cycle longer becomes a long press
        c0 = crst_count;
        run_press(21, 40);
        check("bnd21_crst27", crst_at[27], 1);
        check("bnd21_frz27", frz_at[27], 0);
        check("bnd21_pulses", crst_count - c0, 1);

        // Mid-press reset while frozen
        run_press(10, 24);
        check("pre_mid_frz", frz_at[17], 1);
        btn_raw = 1'b1;
        repeat (10) step();
        check("mid_busy_before", busy, 1);
        rst = 1'b0;
        step();
        check("mid_rst_frz", frz, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_db", btn_db, 0);
        rst = 1'b1;
        repeat (2) step();
        btn_raw = 1'b0;
        c0 = crst_count;
        any_db = 1'b0;
        any_frz = 1'b0;
        any_busy = 1'b0;
        repeat (20) begin
            step();
            any_db   |= btn_db;
            any_frz  |= frz;
            any_busy |= busy;
        end
        check("mid_after_db", any_db, 0);
        check("mid_after_frz", any_frz, 0);
        check("mid_after_busy", any_busy, 0);
        check("mid_after_crst", crst_count - c0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
